// File: rtl/crc24a_pkg.sv
// CRC-24A shared definitions: polynomial, widths, checker FSM states and
// the byte-serial MSB-first CRC update used by the frame checker.
package crc24a_pkg;

  localparam int CRC_W     = 24;
  localparam int CRC_BYTES = 3;
  localparam logic [CRC_W-1:0] CRC24A_POLY = 24'h864CFB;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    REPORT = 1'b1
  } state_e;

  // Advance the CRC register by one byte, most significant bit first.
  function automatic logic [CRC_W-1:0] crc24a_byte_next(
    input logic [CRC_W-1:0] crc_in,
    input logic [7:0]       data_in
  );
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data_in[i];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) begin
        c = c ^ CRC24A_POLY;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc24a_trail_buf.sv
// Three-deep trailing delay line with a registered output stage.
// Each accepted input byte pushes out the byte received three bytes earlier,
// so the trailing CRC bytes of a frame never reach the output. The input byte
// that carries tlast marks the emitted byte as last and flushes the line.
// The caller must only push when out_free is high.
module crc24a_trail_buf
  import crc24a_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_push,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_free,
  output logic [7:0] out_tdata,
  output logic       out_tvalid,
  input  logic       out_tready,
  output logic       out_tlast
);

  logic [7:0] dly0_r;
  logic [7:0] dly1_r;
  logic [7:0] dly2_r;
  logic [1:0] fill_r;
  logic [7:0] out_data_r;
  logic       out_valid_r;
  logic       out_last_r;
  logic       line_full_s;

  assign line_full_s = (fill_r == 2'd3);
  assign out_free    = !out_valid_r || out_tready;
  assign out_tdata   = out_data_r;
  assign out_tvalid  = out_valid_r;
  assign out_tlast   = out_last_r;

  // Delay line: shift on every push, drop its contents at end of frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dly0_r <= 8'h00;
      dly1_r <= 8'h00;
      dly2_r <= 8'h00;
      fill_r <= 2'd0;
    end else if (in_push) begin
      dly0_r <= in_data;
      dly1_r <= dly0_r;
      dly2_r <= dly1_r;
      if (in_last) begin
        fill_r <= 2'd0;
      end else if (!line_full_s) begin
        fill_r <= fill_r + 2'd1;
      end else begin
        fill_r <= fill_r;
      end
    end else begin
      dly0_r <= dly0_r;
      dly1_r <= dly1_r;
      dly2_r <= dly2_r;
      fill_r <= fill_r;
    end
  end

  // Output register: loads the oldest byte when the line is full, drains on handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (in_push && line_full_s) begin
      out_data_r  <= dly2_r;
      out_valid_r <= 1'b1;
      out_last_r  <= in_last;
    end else if (out_valid_r && out_tready) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
    end
  end

endmodule

// File: rtl/crc24a_check.sv
// CRC-24A frame checker (receive side of the crc24a encoder).
// Runs CRC-24A over each AXI-Stream byte frame (payload + 3 CRC bytes) and
// reports one status beat per frame: remainder-zero flag, runt flag and the
// saturating payload length.
// Optional feature: define CRC24A_CHECK_STRIP_EN to add an m_axis output that
// forwards the payload with the CRC bytes removed.
module crc24a_check
  import crc24a_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic             st_valid,
  input  logic             st_ready,
  output logic             st_crc_ok,
  output logic             st_runt,
  output logic [LEN_W-1:0] st_len
`ifdef CRC24A_CHECK_STRIP_EN
  ,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
`endif
);

  localparam int CNT_W = LEN_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_CRC   = CNT_W'(CRC_BYTES);
  localparam logic [LEN_W-1:0] LEN_MAX   = {LEN_W{1'b1}};
  localparam logic [CNT_W-1:0] LEN_MAX_C = {2'b00, LEN_MAX};

  state_e             state_r;
  state_e             state_s;
  logic               ready_en_r;
  logic [CRC_W-1:0]   crc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               st_valid_r;
  logic               st_crc_ok_r;
  logic               st_runt_r;
  logic [LEN_W-1:0]   st_len_r;

  logic [CRC_W-1:0]   crc_next_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [CNT_W-1:0]   cnt_len_s;
  logic [LEN_W-1:0]   len_sat_s;
  logic               runt_s;
  logic               accept_s;
  logic               last_accept_s;
  logic               st_done_s;
  logic               buf_free_s;
  logic               wait_fwd_s;
  logic               fwd_last_done_s;

  assign crc_next_s    = crc24a_byte_next(crc_r, s_axis_tdata);
  assign cnt_inc_s     = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
  assign runt_s        = (cnt_inc_s < CNT_CRC);
  assign cnt_len_s     = runt_s ? {CNT_W{1'b0}} : (cnt_inc_s - CNT_CRC);
  assign len_sat_s     = (cnt_len_s > LEN_MAX_C) ? LEN_MAX : cnt_len_s[LEN_W-1:0];

  assign s_axis_tready = ready_en_r && (state_r == RUN) && buf_free_s;
  assign accept_s      = s_axis_tvalid && s_axis_tready;
  assign last_accept_s = accept_s && s_axis_tlast;
  assign st_done_s     = st_valid_r && st_ready;

  assign st_valid      = st_valid_r;
  assign st_crc_ok     = st_crc_ok_r;
  assign st_runt       = st_runt_r;
  assign st_len        = st_len_r;

`ifdef CRC24A_CHECK_STRIP_EN
  // A frame with at least one payload byte ends with a forwarded tlast beat;
  // the status beat is held back until that beat has left.
  assign wait_fwd_s      = (cnt_inc_s > CNT_CRC);
  assign fwd_last_done_s = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  crc24a_trail_buf u_trail_buf (
    .clock      (clock),
    .reset      (reset),
    .in_push    (accept_s),
    .in_data    (s_axis_tdata),
    .in_last    (s_axis_tlast),
    .out_free   (buf_free_s),
    .out_tdata  (m_axis_tdata),
    .out_tvalid (m_axis_tvalid),
    .out_tready (m_axis_tready),
    .out_tlast  (m_axis_tlast)
  );
`else
  assign buf_free_s      = 1'b1;
  assign wait_fwd_s      = 1'b0;
  assign fwd_last_done_s = 1'b0;
`endif

  // Input ready is held low while in reset and rises on the first clock after.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: collect a frame, then hold until the status beat is taken.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN: begin
        if (last_accept_s) begin
          state_s = REPORT;
        end else begin
          state_s = RUN;
        end
      end
      REPORT: begin
        if (st_done_s) begin
          state_s = RUN;
        end else begin
          state_s = REPORT;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // CRC and byte counter: update per accepted byte, clear once the status is taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_r <= {CRC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == REPORT) && st_done_s) begin
      crc_r <= {CRC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      crc_r <= crc_next_s;
      cnt_r <= cnt_inc_s;
    end else begin
      crc_r <= crc_r;
      cnt_r <= cnt_r;
    end
  end

  // Status beat: captured on the tlast handshake, held stable until accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_valid_r  <= 1'b0;
      st_crc_ok_r <= 1'b0;
      st_runt_r   <= 1'b0;
      st_len_r    <= {LEN_W{1'b0}};
    end else if (last_accept_s) begin
      st_valid_r  <= !wait_fwd_s;
      st_crc_ok_r <= (crc_next_s == {CRC_W{1'b0}}) && !runt_s;
      st_runt_r   <= runt_s;
      st_len_r    <= len_sat_s;
    end else if (st_done_s) begin
      st_valid_r  <= 1'b0;
      st_crc_ok_r <= 1'b0;
      st_runt_r   <= 1'b0;
      st_len_r    <= {LEN_W{1'b0}};
    end else if ((state_r == REPORT) && !st_valid_r && fwd_last_done_s) begin
      st_valid_r  <= 1'b1;
      st_crc_ok_r <= st_crc_ok_r;
      st_runt_r   <= st_runt_r;
      st_len_r    <= st_len_r;
    end else begin
      st_valid_r  <= st_valid_r;
      st_crc_ok_r <= st_crc_ok_r;
      st_runt_r   <= st_runt_r;
      st_len_r    <= st_len_r;
    end
  end

endmodule

// File: tb/tb_crc24a_check.sv
// Scoreboard bench for crc24a_check. Expected status beats (and, with
// CRC24A_CHECK_STRIP_EN, expected forwarded bytes) are derived by polynomial
// long division over the frame bits and queued at stimulus time; monitors pop
// and compare whenever the DUT completes a handshake.
module tb_crc24a_check;

  localparam int LEN_W = 4;
  localparam logic [LEN_W-1:0] LMAX = {LEN_W{1'b1}};

  typedef struct {
    logic             ok;
    logic             runt;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       s_axis_tdata = 8'h00;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic             s_axis_tlast = 1'b0;
  logic             st_valid;
  logic             st_ready = 1'b0;
  logic             st_crc_ok;
  logic             st_runt;
  logic [LEN_W-1:0] st_len;
  logic             hold_st = 1'b0;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef CRC24A_CHECK_STRIP_EN
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tlast;
  logic [8:0] byte_q[$];
`endif

  always #5 clock = ~clock;

  crc24a_check #(.LEN_W(LEN_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_crc_ok     (st_crc_ok),
    .st_runt       (st_runt),
    .st_len        (st_len)
`ifdef CRC24A_CHECK_STRIP_EN
    ,
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Message polynomial (bits MSB first, followed by zero_bytes zero bytes) mod x^24+0x864CFB.
  function automatic logic [23:0] poly_mod(input logic [7:0] msg[$], input int zero_bytes);
    logic [24:0] rem;
    logic [7:0]  b;
    rem = 25'h0;
    for (int i = 0; i < msg.size() + zero_bytes; i++) begin
      b = (i < msg.size()) ? msg[i] : 8'h00;
      for (int k = 7; k >= 0; k--) begin
        rem = {rem[23:0], b[k]};
        if (rem[24]) rem = rem ^ 25'h1864CFB;
      end
    end
    return rem[23:0];
  endfunction

  // Expected outcome of a complete frame, straight from the frame rules.
  task automatic push_expect(input logic [7:0] msg[$]);
    exp_t e;
    int   n;
    n      = msg.size();
    e.runt = (n < 3);
    e.ok   = !e.runt && (poly_mod(msg, 0) == 24'h0);
    e.len  = e.runt ? '0 : (((n - 3) > int'(LMAX)) ? LMAX : LEN_W'(n - 3));
    exp_q.push_back(e);
`ifdef CRC24A_CHECK_STRIP_EN
    for (int i = 0; i < n - 3; i++) byte_q.push_back({(i == n - 4), msg[i]});
`endif
  endtask

  // Drive bytes with random idle gaps; tlast on final byte when with_last.
  task automatic send_bytes(input logic [7:0] msg[$], input bit with_last);
    bit r;
    bit done;
    for (int i = 0; i < msg.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'($urandom);
        s_axis_tlast  = 1'($urandom);
        @(posedge clock); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = msg[i];
      s_axis_tlast  = with_last && (i == msg.size() - 1);
      done = 1'b0;
      for (int c = 0; c < 500 && !done; c++) begin
        @(negedge clock); r = s_axis_tready;
        @(posedge clock); #1;
        done = r;
      end
      if (!done) check("s_axis_accept_timeout", 32'd0, 32'd1);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] msg[$]);
    push_expect(msg);
    send_bytes(msg, 1'b1);
  endtask

  task automatic valid_frame(input int plen, output logic [7:0] msg[$]);
    logic [23:0] c;
    msg = {};
    for (int i = 0; i < plen; i++) msg.push_back(8'($urandom));
    c = poly_mod(msg, 3);
    msg.push_back(c[23:16]);
    msg.push_back(c[15:8]);
    msg.push_back(c[7:0]);
  endtask

  // Status monitor: pop and compare on every status handshake.
  always @(negedge clock) begin
    if (!reset && st_valid && st_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_status", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("st_crc_ok", 32'(st_crc_ok), 32'(e.ok));
        check("st_runt", 32'(st_runt), 32'(e.runt));
        check("st_len", 32'(st_len), 32'(e.len));
      end
    end
  end

`ifdef CRC24A_CHECK_STRIP_EN
  // Forwarded-payload monitor.
  always @(negedge clock) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      if (byte_q.size() == 0) begin
        check("unexpected_m_axis", 32'd1, 32'd0);
      end else begin
        logic [8:0] b;
        b = byte_q.pop_front();
        check("m_axis_tdata", 32'(m_axis_tdata), 32'(b[7:0]));
        check("m_axis_tlast", 32'(m_axis_tlast), 32'(b[8]));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock); #1;
      m_axis_tready = ($urandom_range(0, 2) != 0);
    end
  end
`endif

  // Status ready: random unless a test holds it low.
  initial begin
    forever begin
      @(posedge clock); #1;
      st_ready = hold_st ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [7:0] f[$];
    bit         seen;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_tready", 32'(s_axis_tready), 32'd0);
    check("reset_st_valid", 32'(st_valid), 32'd0);
`ifdef CRC24A_CHECK_STRIP_EN
    check("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
`endif
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); @(negedge clock);
    check("post_reset_tready", 32'(s_axis_tready), 32'd1);
    @(posedge clock); #1;

    // Known good frame; status one cycle after the tlast handshake
    f = '{8'h01, 8'h86, 8'h4C, 8'hFB};
    send_frame(f);
`ifndef CRC24A_CHECK_STRIP_EN
    @(negedge clock);
    check("status_latency", 32'(st_valid), 32'd1);
    @(posedge clock); #1;
`endif

    // All-zero frame, then single bit error
    f = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(f);
    f = '{8'h01, 8'h86, 8'h4C, 8'hFA};
    send_frame(f);

    // Runt frames
    f = '{8'h01, 8'h86};
    send_frame(f);
    f = '{8'h55};
    send_frame(f);
    f = '{8'h12, 8'h34, 8'h56};
    send_frame(f);

    // Status backpressure: stable outputs and no input acceptance
    hold_st = 1'b1;
    valid_frame(2, f);
    send_frame(f);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clock); seen = st_valid;
    end
    check("hold_st_valid_seen", 32'(seen), 32'd1);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("hold_tready_low", 32'(s_axis_tready), 32'd0);
      check("hold_st_valid", 32'(st_valid), 32'd1);
      check("hold_st_len", 32'(st_len), 32'd2);
      check("hold_st_ok", 32'(st_crc_ok), 32'd1);
    end
    @(posedge clock); #1;
    s_axis_tvalid = 1'b0;
    hold_st = 1'b0;
    valid_frame(1, f);
    send_frame(f);

    // Reset mid-frame: partial frame discarded, no status
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(posedge clock);
    #1;
    f = '{8'h01, 8'h86};
    send_bytes(f, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_tready", 32'(s_axis_tready), 32'd0);
    check("midreset_st_valid", 32'(st_valid), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    f = '{8'h01, 8'h86, 8'h4C, 8'hFB};
    send_frame(f);

    // Saturating length: 17-byte payload and a frame long enough to saturate the counter
    valid_frame(17, f);
    send_frame(f);
    valid_frame(70, f);
    send_frame(f);

    // Strip example payload AA 01 with valid CRC
    f = '{8'hAA, 8'h01};
    valid_frame(0, f);
    f = '{8'hAA, 8'h01};
    begin
      logic [23:0] c;
      c = poly_mod(f, 3);
      f.push_back(c[23:16]); f.push_back(c[15:8]); f.push_back(c[7:0]);
    end
    send_frame(f);

    // Randomized frames: mixed lengths, some corrupted, some runts
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        f = {};
        repeat ($urandom_range(1, 2)) f.push_back(8'($urandom));
      end else begin
        valid_frame($urandom_range(0, 20), f);
        if ($urandom_range(0, 3) == 0) begin
          int idx;
          idx = $urandom_range(0, f.size() - 1);
          f[idx] = f[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
      end
      send_frame(f);
    end

    // Drain
    for (int c = 0; c < 2000 && exp_q.size() != 0; c++) @(posedge clock);
    check("status_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef CRC24A_CHECK_STRIP_EN
    for (int c = 0; c < 2000 && byte_q.size() != 0; c++) @(posedge clock);
    check("payload_queue_empty", 32'(byte_q.size()), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
